// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the four-channel push-button debouncer:
//   channel FSM state encoding, default timing constants, channel count
//   and a small population-count helper used by the top-level decode.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF           = 16;
  localparam int NUM_CH              = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CNT   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CNT = 2'd3
  } ch_state_e;

  // Number of set bits in a channel vector (0..NUM_CH).
  function automatic logic [2:0] count_set(input logic [NUM_CH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch
//   One debounced button channel: 2-FF synchroniser followed by a
//   press/release FSM with a terminal-count compare on an up-counter.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   RELEASED    | stable released, level = 0
//   PRESS_CNT   | sync went high, counting stable-high samples, level = 0
//   PRESSED     | stable pressed, level = 1
//   RELEASE_CNT | sync went low, counting stable-low samples, level = 1
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   raw         raw button line, asynchronous to clk
//   level       registered debounced level (1 = pressed)
//   press_pulse one-cycle pulse when a press is accepted
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_q;
  logic             sync_q;
  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= raw;
      sync_q      <= sync_meta_q;
    end
  end

  // The counter is cleared on every state entry, so it can never run past
  // CNT_LAST and needs no wrap protection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync_q) begin
            state_q <= PRESS_CNT;
            cnt_q   <= '0;
          end
        end
        PRESS_CNT: begin
          if (!sync_q) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_q) begin
            state_q <= RELEASE_CNT;
            cnt_q   <= '0;
          end
        end
        RELEASE_CNT: begin
          if (sync_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/debounce_4ch.sv
// debounce_4ch
//   Four independent debounced button channels plus a registered
//   exclusivity decode for the downstream 4-to-2 encoder.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   btn_raw     raw button lines, asynchronous, may bounce
//   level       debounced level per channel
//   press_pulse one-cycle pulse per channel on an accepted press
//   onehot      level when exactly one channel is pressed, else 0
//   multi_press high while two or more channels are pressed
module debounce_4ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] onehot,
  output logic              multi_press
);

  if ((DEBOUNCE_CYCLES < 2) || ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES))) begin : g_bad_param
    $error("debounce_4ch: DEBOUNCE_CYCLES must be >= 2 and <= 2**CNT_W");
  end

  logic [NUM_CH-1:0] level_w;
  logic [NUM_CH-1:0] pulse_w;
  logic [2:0]        n_set;
  logic [NUM_CH-1:0] onehot_d;
  logic [NUM_CH-1:0] onehot_q;
  logic              multi_d;
  logic              multi_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[g]),
      .level      (level_w[g]),
      .press_pulse(pulse_w[g])
    );
  end

  always_comb begin
    n_set    = count_set(level_w);
    onehot_d = (n_set == 3'd1) ? level_w : '0;
    multi_d  = (n_set >= 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

  assign level       = level_w;
  assign press_pulse = pulse_w;
  assign onehot      = onehot_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_debounce_4ch.sv
module tb_debounce_4ch;

  localparam int DC = 4;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] oh;
    logic       mp;
  } exp_t;

  typedef struct packed {
    logic [3:0] btn;
    logic [7:0] n;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] level;
  logic [3:0] press_pulse;
  logic [3:0] onehot;
  logic       multi_press;

  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  vec_t tbl[13];

  debounce_4ch #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .level      (level),
    .press_pulse(press_pulse),
    .onehot     (onehot),
    .multi_press(multi_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] lvl, input logic [3:0] pls,
                              input logic [3:0] oh, input logic mp);
    exp_t e;
    e.lvl = lvl;
    e.pls = pls;
    e.oh  = oh;
    e.mp  = mp;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] btn, input int n, input exp_t e);
    vec_t v;
    v.btn = btn;
    v.n   = 8'(n);
    v.e   = e;
    return v;
  endfunction

  task automatic cmp4(input string name, input string fld, input logic [3:0] got,
                      input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %b expected %b", name, fld, got, exp);
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", name);
      return;
    end
    e = sb.pop_front();
    cmp4(name, "level", level, e.lvl);
    cmp4(name, "press_pulse", press_pulse, e.pls);
    cmp4(name, "onehot", onehot, e.oh);
    cmp4(name, "multi_press", {3'b000, multi_press}, {3'b000, e.mp});
  endtask

  // Drive btn, expect e after n rising edges (sampled 1 time unit later).
  task automatic drive_hold(input logic [3:0] btn, input int n, input exp_t e,
                            input string name);
    btn_raw = btn;
    sb.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic step(input logic [3:0] btn, input exp_t e, input string name);
    drive_hold(btn, 1, e, name);
  endtask

  initial begin
    logic [3:0] bounce;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    btn_raw = 4'b0000;

    // Level changes are seen after edge DC+3 counted from the drive point
    // (edge 1 = E0, level rises after E0+DC+2); onehot/multi one edge later.
    tbl[0]  = mkv(4'b0010, DC+2, mk(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tbl[1]  = mkv(4'b0010, 1,    mk(4'b0010, 4'b0010, 4'b0000, 1'b0));
    tbl[2]  = mkv(4'b0010, 1,    mk(4'b0010, 4'b0000, 4'b0010, 1'b0));
    tbl[3]  = mkv(4'b0000, DC+2, mk(4'b0010, 4'b0000, 4'b0010, 1'b0));
    tbl[4]  = mkv(4'b0000, 1,    mk(4'b0000, 4'b0000, 4'b0010, 1'b0));
    tbl[5]  = mkv(4'b0000, 1,    mk(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tbl[6]  = mkv(4'b0001, DC+3, mk(4'b0001, 4'b0001, 4'b0000, 1'b0));
    tbl[7]  = mkv(4'b0001, 1,    mk(4'b0001, 4'b0000, 4'b0001, 1'b0));
    tbl[8]  = mkv(4'b0101, DC+3, mk(4'b0101, 4'b0100, 4'b0001, 1'b0));
    tbl[9]  = mkv(4'b0101, 1,    mk(4'b0101, 4'b0000, 4'b0000, 1'b1));
    tbl[10] = mkv(4'b0100, DC+3, mk(4'b0100, 4'b0000, 4'b0000, 1'b1));
    tbl[11] = mkv(4'b0100, 1,    mk(4'b0100, 4'b0000, 4'b0100, 1'b0));
    tbl[12] = mkv(4'b0000, DC+4, mk(4'b0000, 4'b0000, 4'b0000, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0));
    check_out("reset");
    rst = 1'b0;
    repeat (2) step(4'b0000, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), "idle");

    // Clean press, release and multi-press table
    for (int i = 0; i < 13; i++) begin
      drive_hold(tbl[i].btn, int'(tbl[i].n), tbl[i].e, $sformatf("vec%0d", i));
    end

    // Bounce on channel 0: 1,0,1,1,0 then quiet; nothing may be accepted
    bounce = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      case (i)
        0, 2, 3: bounce = 4'b0001;
        default: bounce = 4'b0000;
      endcase
      step(bounce, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), $sformatf("bounce%0d", i));
    end

    // Release glitch on channel 3: short low must not drop level or re-pulse
    drive_hold(4'b1000, DC+3, mk(4'b1000, 4'b1000, 4'b0000, 1'b0), "glitch_press");
    step(4'b1000, mk(4'b1000, 4'b0000, 4'b1000, 1'b0), "glitch_settle");
    for (int i = 0; i < 2; i++)
      step(4'b0000, mk(4'b1000, 4'b0000, 4'b1000, 1'b0), $sformatf("glitch_low%0d", i));
    for (int i = 0; i < 10; i++)
      step(4'b1000, mk(4'b1000, 4'b0000, 4'b1000, 1'b0), $sformatf("glitch_hold%0d", i));
    drive_hold(4'b0000, DC+4, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), "glitch_release");

    // Reset mid-count on channel 3
    drive_hold(4'b1000, 4, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), "rmc_pre");
    rst = 1'b1;
    #1;
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0));
    check_out("rmc_in_reset");
    repeat (2) step(4'b1000, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), "rmc_held");
    rst = 1'b0;
    for (int i = 1; i <= DC+2; i++)
      step(4'b1000, mk(4'b0000, 4'b0000, 4'b0000, 1'b0), $sformatf("rmc_wait%0d", i));
    step(4'b1000, mk(4'b1000, 4'b1000, 4'b0000, 1'b0), "rmc_rise");
    for (int i = 0; i < 4; i++)
      step(4'b1000, mk(4'b1000, 4'b0000, 4'b1000, 1'b0), $sformatf("rmc_after%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
